// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into the stall bus, sequences
// exception/ERET recovery (flush, then fetch redirect) and counts stalled cycles.
`ifndef EXC_CODE_BUS
`define EXC_CODE_BUS 4:0
`endif
`ifndef EXC_NONE
`define EXC_NONE 5'h00
`endif

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          STALL_W    = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stallreq_if,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 exc_valid,
  input  logic                 exc_is_eret,
  input  logic [`EXC_CODE_BUS] exc_code_i,
  input  logic [31:0]          cp0_epc,
  input  logic                 redirect_ready,
  output logic [STALL_W-1:0]   stall,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [`EXC_CODE_BUS] exc_code_o,
  output logic                 busy,
  output logic [31:0]          stall_cnt
);

  // Handshake: redirect_valid rises with flush and holds, with redirect_pc stable,
  // until the first rising edge where redirect_ready is also 1; it drops the next cycle.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        target_pc_q;
  logic [`EXC_CODE_BUS] exc_code_q;
  logic [31:0]        cnt_q;
  logic               flush_q;
  logic               rv_q;
  logic               busy_q;

  // Stall for stage k with stage k+1 free makes k+1 load a bubble.
  always_comb begin
    stall = '0;
    case (state_q)
      ST_RUN: begin
        if (exc_valid)         stall = '0;
        else if (stallreq_mem) stall = STALL_W'(6'b011111);
        else if (stallreq_ex)  stall = STALL_W'(6'b001111);
        else if (stallreq_id)  stall = STALL_W'(6'b000111);
        else if (stallreq_if)  stall = STALL_W'(6'b000011);
        else                   stall = '0;
      end
      ST_FLUSH:    stall = '0;
      ST_REDIRECT: stall = STALL_W'(6'b000011);
      default:     stall = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      target_pc_q <= 32'h0;
      exc_code_q  <= `EXC_NONE;
      cnt_q       <= 32'h0;
      flush_q     <= 1'b0;
      rv_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (exc_valid) begin
            target_pc_q <= exc_is_eret ? cp0_epc : EXC_VECTOR;
            exc_code_q  <= exc_code_i;
            state_q     <= ST_FLUSH;
            flush_q     <= 1'b1;
            rv_q        <= 1'b1;
            busy_q      <= 1'b1;
          end else if (stall[0] && cnt_q != 32'hFFFFFFFF) begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b0;
          if (redirect_ready) begin
            state_q <= ST_RUN;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          // exc_valid here belongs to a flushed instruction and is ignored.
          if (redirect_ready) begin
            state_q <= ST_RUN;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          flush_q <= 1'b0;
          rv_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = target_pc_q;
  assign exc_code_o     = exc_code_q;
  assign busy           = busy_q;
  assign stall_cnt      = cnt_q;

endmodule
